add_round_key_stage: RTL and testbench

//  Registered AddRoundKey stage placed directly downstream of mixColumns in the AES round datapath.

---
 rtl/add_round_key_stage.sv | 139 +++++++++++++
 tb/tb_add_round_key_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/add_round_key_stage.sv
// Registered AddRoundKey stage: selects the mixColumns or bypass state by round,
// XORs it with the stored round key, and presents it through a 1-entry skid buffer.
module add_round_key_stage #(
   parameter int NR     = 10,
   parameter int RIDX_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              key_we,
   input  logic [RIDX_W-1:0] key_waddr,
   input  logic [127:0]      key_wdata,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [127:0]      in_mixed,
   input  logic [127:0]      in_bypass,
   input  logic [RIDX_W-1:0] in_round,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [127:0]      out_state,
   output logic [RIDX_W-1:0] out_round,
   output logic              out_last,
   output logic              err_round,
   output logic [15:0]       blk_cnt
);

   localparam logic [RIDX_W-1:0] LAST_RND = RIDX_W'(NR);

   logic [127:0] key_q [0:NR];

   logic              out_valid_q, out_valid_d;
   logic [127:0]      out_state_q, out_state_d;
   logic [RIDX_W-1:0] out_round_q, out_round_d;
   logic              out_last_q,  out_last_d;
   logic              skid_full_q, skid_full_d;
   logic [127:0]      skid_state_q, skid_state_d;
   logic [RIDX_W-1:0] skid_round_q, skid_round_d;
   logic              skid_last_q,  skid_last_d;
   logic              err_q, err_d;
   logic [15:0]       cnt_q, cnt_d;

   logic              acc, bad, good_acc, fire, out_free;
   logic [127:0]      key_rd, sel, res_state;
   logic              res_last;

   // Valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
   // in_ready depends only on rst_n and the registered skid flag, never on out_ready.
   assign in_ready = rst_n & ~skid_full_q;
   assign acc      = in_valid & in_ready;
   assign bad      = in_round > LAST_RND;
   assign good_acc = acc & ~bad;
   assign fire     = out_valid_q & out_ready;
   assign out_free = ~out_valid_q | out_ready;

   // Key store is deliberately not reset; the read here sees the pre-write value.
   always_ff @(posedge clk) begin
      if (key_we && (key_waddr <= LAST_RND)) begin
         key_q[key_waddr] <= key_wdata;
      end
   end

   always_comb begin
      key_rd = '0;
      if (!bad) begin
         key_rd = key_q[in_round];
      end
      res_last  = (in_round == LAST_RND);
      sel       = ((in_round == '0) || res_last) ? in_bypass : in_mixed;
      res_state = sel ^ key_rd;
   end

   always_comb begin
      out_valid_d  = out_valid_q;
      out_state_d  = out_state_q;
      out_round_d  = out_round_q;
      out_last_d   = out_last_q;
      skid_full_d  = skid_full_q;
      skid_state_d = skid_state_q;
      skid_round_d = skid_round_q;
      skid_last_d  = skid_last_q;
      err_d        = acc & bad;
      cnt_d        = fire ? cnt_q + 16'd1 : cnt_q;
      if (out_free) begin
         if (skid_full_q) begin
            out_valid_d = 1'b1;
            out_state_d = skid_state_q;
            out_round_d = skid_round_q;
            out_last_d  = skid_last_q;
            skid_full_d = 1'b0;
         end else if (good_acc) begin
            out_valid_d = 1'b1;
            out_state_d = res_state;
            out_round_d = in_round;
            out_last_d  = res_last;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (good_acc) begin
         // Output is stalled: park the new block; skid is known empty since in_ready was 1.
         skid_full_d  = 1'b1;
         skid_state_d = res_state;
         skid_round_d = in_round;
         skid_last_d  = res_last;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_state_q  <= '0;
         out_round_q  <= '0;
         out_last_q   <= 1'b0;
         skid_full_q  <= 1'b0;
         skid_state_q <= '0;
         skid_round_q <= '0;
         skid_last_q  <= 1'b0;
         err_q        <= 1'b0;
         cnt_q        <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_state_q  <= out_state_d;
         out_round_q  <= out_round_d;
         out_last_q   <= out_last_d;
         skid_full_q  <= skid_full_d;
         skid_state_q <= skid_state_d;
         skid_round_q <= skid_round_d;
         skid_last_q  <= skid_last_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_state = out_state_q;
   assign out_round = out_round_q;
   assign out_last  = out_last_q;
   assign err_round = err_q;
   assign blk_cnt   = cnt_q;

endmodule

// File: tb/tb_add_round_key_stage.sv
// Bench for add_round_key_stage: directed FIPS/backpressure/hazard/reset steps, then
// random traffic, all compared against a queue-based reference model.
module tb_add_round_key_stage;

   localparam int NR = 10;
   localparam int RW = 4;

   logic          clk;
   logic          rst_n;
   logic          key_we;
   logic [RW-1:0] key_waddr;
   logic [127:0]  key_wdata;
   logic          in_valid;
   logic          in_ready;
   logic [127:0]  in_mixed;
   logic [127:0]  in_bypass;
   logic [RW-1:0] in_round;
   logic          out_valid;
   logic          out_ready;
   logic [127:0]  out_state;
   logic [RW-1:0] out_round;
   logic          out_last;
   logic          err_round;
   logic [15:0]   blk_cnt;

   add_round_key_stage #(.NR(NR), .RIDX_W(RW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_we    (key_we),
      .key_waddr (key_waddr),
      .key_wdata (key_wdata),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mixed  (in_mixed),
      .in_bypass (in_bypass),
      .in_round  (in_round),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .out_round (out_round),
      .out_last  (out_last),
      .err_round (err_round),
      .blk_cnt   (blk_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: round keys, pending blocks {last, round, state}, counter, error pulse.
   logic [127:0]          mkey [0:NR];
   logic [1+RW+127:0]     exp_q [$];
   logic [15:0]           cnt_exp;
   logic                  err_exp;
   int                    checks;
   int                    errors;

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic logic [1+RW+127:0] ref_blk(logic [RW-1:0] r, logic [127:0] mx, logic [127:0] bp);
      logic [127:0] s;
      s = ((r == 0) || (r == NR)) ? bp : mx;
      s = s ^ mkey[r];
      return {(r == NR), r, s};
   endfunction

   task automatic chk(string tag, logic [1+RW+127:0] obs, logic [1+RW+127:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // One clock: compare outputs mid-cycle, advance the model, then step past the edge.
   task automatic tick();
      logic ready_m;
      @(negedge clk);
      chk("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) chk("out_data", {out_last, out_round, out_state}, exp_q[0]);
      ready_m = rst_n && (exp_q.size() < 2);
      chk("in_ready", in_ready, ready_m);
      chk("err_round", err_round, err_exp);
      chk("blk_cnt", blk_cnt, cnt_exp);
      if (!rst_n) begin
         exp_q.delete();
         cnt_exp = '0;
         err_exp = 1'b0;
      end else begin
         err_exp = 1'b0;
         if (out_ready && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            cnt_exp = cnt_exp + 16'd1;
         end
         if (in_valid && ready_m) begin
            if (in_round > NR) err_exp = 1'b1;
            else exp_q.push_back(ref_blk(in_round, in_mixed, in_bypass));
         end
      end
      if (key_we && key_waddr <= NR) mkey[key_waddr] = key_wdata;
      @(posedge clk);
      #1;
   endtask

   task automatic write_key(int idx, logic [127:0] k);
      key_we    = 1'b1;
      key_waddr = RW'(idx);
      key_wdata = k;
      tick();
      key_we    = 1'b0;
   endtask

   task automatic send(logic [RW-1:0] r, logic [127:0] mx, logic [127:0] bp);
      in_valid  = 1'b1;
      in_round  = r;
      in_mixed  = mx;
      in_bypass = bp;
      tick();
      in_valid  = 1'b0;
   endtask

   initial begin
      logic [127:0] old3, new3, m, m2;
      logic [15:0]  cnt_before;
      checks    = 0;
      errors    = 0;
      cnt_exp   = '0;
      err_exp   = 1'b0;
      rst_n     = 1'b0;
      key_we    = 1'b0;
      key_waddr = '0;
      key_wdata = '0;
      in_valid  = 1'b0;
      in_mixed  = '0;
      in_bypass = '0;
      in_round  = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_state", out_state, 128'h0);
      chk("rst_out_round", out_round, 4'h0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_err", err_round, 1'b0);
      chk("rst_blk_cnt", blk_cnt, 16'h0);
      chk("rst_in_ready", in_ready, 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i <= NR; i++) write_key(i, rnd128());

      // T1: FIPS-197 C.1 initial key addition
      write_key(0, 128'h000102030405060708090a0b0c0d0e0f);
      send(4'd0, rnd128(), 128'h00112233445566778899aabbccddeeff);
      chk("t1_state", out_state, 128'h00102030405060708090a0b0c0d0e0f0);
      chk("t1_round", out_round, 4'd0);
      chk("t1_last", out_last, 1'b0);
      chk("t1_valid", out_valid, 1'b1);
      tick();

      // T2: mid round uses mixColumns, final round uses bypass
      write_key(5, {128{1'b1}});
      write_key(NR, {128{1'b1}});
      send(4'd5, 128'h0, {16{8'haa}});
      chk("t2_mid_state", out_state, {128{1'b1}});
      send(4'(NR), 128'h0, {16{8'haa}});
      chk("t2_fin_state", out_state, {16{8'h55}});
      chk("t2_fin_last", out_last, 1'b1);
      tick();

      // T3: backpressure fills output register then skid
      cnt_before = blk_cnt;
      out_ready  = 1'b0;
      in_valid   = 1'b1;
      in_round   = 4'd2;
      in_mixed   = rnd128();
      in_bypass  = rnd128();
      tick();
      in_round   = 4'd3;
      in_mixed   = rnd128();
      tick();
      chk("t3_skid_ready", in_ready, 1'b0);
      in_round   = 4'd4;
      in_mixed   = rnd128();
      tick();
      chk("t3_hold_ready", in_ready, 1'b0);
      out_ready  = 1'b1;
      tick();
      tick();
      in_valid   = 1'b0;
      repeat (3) tick();
      chk("t3_blk_cnt", blk_cnt, cnt_before + 16'd3);

      // T4: bad round is swallowed with an error pulse
      send(4'd11, rnd128(), rnd128());
      chk("t4_err_pulse", err_round, 1'b1);
      chk("t4_no_out", out_valid, 1'b0);
      tick();
      chk("t4_err_clear", err_round, 1'b0);
      // T4: same-cycle key write and accept reads the old key
      old3      = mkey[3];
      new3      = rnd128();
      m         = rnd128();
      key_we    = 1'b1;
      key_waddr = 4'd3;
      key_wdata = new3;
      send(4'd3, m, rnd128());
      key_we    = 1'b0;
      chk("t4_old_key", out_state, m ^ old3);
      m2 = rnd128();
      send(4'd3, m2, rnd128());
      chk("t4_new_key", out_state, m2 ^ new3);
      write_key(12, rnd128());
      tick();

      // T5: reset with skid full discards everything
      out_ready = 1'b0;
      send(4'd1, rnd128(), rnd128());
      send(4'd2, rnd128(), rnd128());
      rst_n = 1'b0;
      tick();
      chk("t5_out_valid", out_valid, 1'b0);
      chk("t5_blk_cnt", blk_cnt, 16'h0);
      chk("t5_in_ready", in_ready, 1'b0);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      tick();
      chk("t5_ready_back", in_ready, 1'b1);
      for (int r = 0; r <= NR; r++) send(RW'(r), rnd128(), rnd128());
      repeat (2) tick();

      // Random traffic with random stalls, bad rounds and key updates
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 9) < 7);
         in_round  = ($urandom_range(0, 7) == 0) ? RW'($urandom_range(11, 15)) : RW'($urandom_range(0, NR));
         in_mixed  = rnd128();
         in_bypass = rnd128();
         key_we    = ($urandom_range(0, 9) == 0);
         key_waddr = RW'($urandom_range(0, 15));
         key_wdata = rnd128();
         tick();
      end
      in_valid  = 1'b0;
      key_we    = 1'b0;
      out_ready = 1'b1;
      repeat (4) tick();
      chk("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
